// File: rtl/vga_scan_driver.sv
// Raster counters, sync/blank decode and an SX_OFFS-deep alignment line feeding the 12-bit VGA pins.
// Optional feature: define VGA_BORDER_EN to paint BORDER_RGB on the outermost active rows/columns.
module vga_scan_driver #(
   parameter int          COORDINATE_WIDTH = 10,
   parameter int          H_RES            = 640,
   parameter int          H_FP             = 16,
   parameter int          H_SYNC           = 96,
   parameter int          H_BP             = 48,
   parameter int          V_RES            = 480,
   parameter int          V_FP             = 10,
   parameter int          V_SYNC           = 2,
   parameter int          V_BP             = 33,
   parameter int          SX_OFFS          = 2,
   parameter logic [11:0] FG_RGB           = 12'hFFF,
   parameter logic [11:0] BG_RGB           = 12'h00F
`ifdef VGA_BORDER_EN
   ,
   parameter logic [11:0] BORDER_RGB       = 12'hF00
`endif
) (
   input  logic                        clk,
   input  logic                        reset_button,
   output logic [COORDINATE_WIDTH-1:0] horiz_pos,
   output logic [COORDINATE_WIDTH-1:0] vert_pos,
   output logic                        line,
   output logic                        frame,
   input  logic                        pix,
   input  logic                        drawing,
   output logic [3:0]                  vga_r,
   output logic [3:0]                  vga_g,
   output logic [3:0]                  vga_b,
   output logic                        vga_hs,
   output logic                        vga_vs
);

   localparam int CW      = COORDINATE_WIDTH;
   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_RES);
   localparam logic [CW-1:0] V_ACT  = CW'(V_RES);
   localparam logic [CW-1:0] HS_ON  = CW'(H_RES + H_FP);
   localparam logic [CW-1:0] HS_OFF = CW'(H_RES + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_ON  = CW'(V_RES + V_FP);
   localparam logic [CW-1:0] VS_OFF = CW'(V_RES + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
   localparam logic [CW-1:0] H_EDGE = CW'(H_RES - 1);
   localparam logic [CW-1:0] V_EDGE = CW'(V_RES - 1);
`endif

   // One delay-line stage: timing decode plus, for the border, the coordinate it belongs to.
   typedef struct packed {
`ifdef VGA_BORDER_EN
      logic [CW-1:0] h;
      logic [CW-1:0] v;
`endif
      logic          de;
      logic          hs_n;
      logic          vs_n;
   } tap_t;

   logic [CW-1:0]            h_q, h_d, v_q, v_d;
   logic                     line_q, line_d, frame_q, frame_d;
   logic                     h_wrap;
   tap_t                     raw, tap;
   tap_t [SX_OFFS-1:0]       pipe_q, pipe_d;
   logic [11:0]              rgb_q, rgb_d;
   logic                     hs_q, hs_d, vs_q, vs_d;
`ifdef VGA_BORDER_EN
   logic                     border;
`endif

   always_comb begin
      h_wrap  = (h_q == H_LAST);
      h_d     = h_wrap ? '0 : h_q + CW'(1);
      v_d     = v_q;
      if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      // Pulses are computed from the next count so they line up with the counter reading 0.
      line_d  = (h_d == '0);
      frame_d = line_d && (v_d == '0);
   end

   always_comb begin
      raw      = '0;
      raw.de   = (h_q < H_ACT) && (v_q < V_ACT);
      raw.hs_n = !((h_q >= HS_ON) && (h_q < HS_OFF));
      raw.vs_n = !((v_q >= VS_ON) && (v_q < VS_OFF));
`ifdef VGA_BORDER_EN
      raw.h    = h_q;
      raw.v    = v_q;
`endif
      pipe_d    = '0;
      pipe_d[0] = raw;
      for (int i = 1; i < SX_OFFS; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_comb begin
      tap  = pipe_q[SX_OFFS-1];
      hs_d = tap.hs_n;
      vs_d = tap.vs_n;
`ifdef VGA_BORDER_EN
      border = (tap.h == '0) || (tap.h == H_EDGE) || (tap.v == '0) || (tap.v == V_EDGE);
`endif
      if (!tap.de)             rgb_d = '0;
      else if (drawing && pix) rgb_d = FG_RGB;
`ifdef VGA_BORDER_EN
      else if (border)         rgb_d = BORDER_RGB;
`endif
      else                     rgb_d = BG_RGB;
   end

   always_ff @(posedge clk or negedge reset_button) begin
      if (!reset_button) begin
         h_q     <= H_LAST;
         v_q     <= V_LAST;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         for (int i = 0; i < SX_OFFS; i++) begin
            pipe_q[i]      <= '0;
            pipe_q[i].hs_n <= 1'b1;
            pipe_q[i].vs_n <= 1'b1;
         end
         rgb_q   <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         pipe_q  <= pipe_d;
         rgb_q   <= rgb_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign horiz_pos = h_q;
   assign vert_pos  = v_q;
   assign line      = line_q;
   assign frame     = frame_q;
   assign vga_r     = rgb_q[11:8];
   assign vga_g     = rgb_q[7:4];
   assign vga_b     = rgb_q[3:0];
   assign vga_hs    = hs_q;
   assign vga_vs    = vs_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: cycle-index model checked every cycle plus directed literal checks.
// Vertical timing is shortened (67 lines) so whole frames fit in a short run; horizontal is full size.
module tb_vga_scan_driver;

   localparam int HT  = 800;
   localparam int VT  = 67;
   localparam int HRS = 640;
   localparam int VRS = 60;
   localparam int SX  = 2;
`ifdef VGA_BORDER_EN
   localparam logic [11:0] EDGE_RGB = 12'hF00;
`else
   localparam logic [11:0] EDGE_RGB = 12'h00F;
`endif

   logic       clk = 1'b0;
   logic       reset_button = 1'b1;
   logic       pix = 1'b0, drawing = 1'b0;
   logic [9:0] horiz_pos, vert_pos;
   logic       line, frame;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs;

   int   nc = 0, nf = 0;
   int   k = 0;
   logic lp = 1'b0, ld = 1'b0;
   int   nlines = 0, nframes = 0;
   bit   chk_on = 1'b0;

   vga_scan_driver #(
      .COORDINATE_WIDTH(10), .H_RES(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_RES(60), .V_FP(2), .V_SYNC(2), .V_BP(3), .SX_OFFS(SX),
      .FG_RGB(12'hFFF), .BG_RGB(12'h00F)
   ) dut (
      .clk(clk), .reset_button(reset_button), .horiz_pos(horiz_pos), .vert_pos(vert_pos),
      .line(line), .frame(frame), .pix(pix), .drawing(drawing),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
   );

   always #5 clk = ~clk;

   // k = rising edges since reset release; lp/ld = renderer inputs captured at the latest edge.
   always @(posedge clk or negedge reset_button) begin
      if (!reset_button) k <= 0;
      else begin
         k  <= k + 1;
         lp <= pix;
         ld <= drawing;
         if (line)  nlines  <= nlines + 1;
         if (frame) nframes <= nframes + 1;
      end
   end

   function automatic logic [11:0] colour(int hc, int vc, logic d, logic p);
      if (!(hc < HRS && vc < VRS)) return 12'h000;
      if (d && p) return 12'hFFF;
`ifdef VGA_BORDER_EN
      if (hc == 0 || hc == HRS-1 || vc == 0 || vc == VRS-1) return 12'hF00;
`endif
      return 12'h00F;
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         int eh, ev, kc, hc, vc;
         logic el, efr, ehs, evs;
         logic [11:0] ergb;
         logic [37:0] got, exp;
         if (k == 0) begin
            eh = HT-1; ev = VT-1; el = 1'b0; efr = 1'b0;
         end else begin
            eh = (k-1) % HT; ev = ((k-1) / HT) % VT;
            el = (eh == 0); efr = el && (ev == 0);
         end
         kc = k - SX - 1;
         if (kc < 1) begin
            ergb = 12'h000; ehs = 1'b1; evs = 1'b1;
         end else begin
            hc = (kc-1) % HT; vc = ((kc-1) / HT) % VT;
            ergb = colour(hc, vc, ld, lp);
            ehs  = !(hc >= 656 && hc < 752);
            evs  = !(vc >= 62 && vc < 64);
         end
         got = {horiz_pos, vert_pos, line, frame, vga_r, vga_g, vga_b, vga_hs, vga_vs, 2'b00};
         exp = {10'(eh), 10'(ev), el, efr, ergb, ehs, evs, 2'b00};
         nc++;
         if (got !== exp) begin
            nf++;
            $display("FAIL model k=%0d: got h=%0d v=%0d l=%b f=%b rgb=%h hs=%b vs=%b, want h=%0d v=%0d l=%b f=%b rgb=%h hs=%b vs=%b",
                     k, horiz_pos, vert_pos, line, frame, {vga_r, vga_g, vga_b}, vga_hs, vga_vs,
                     eh, ev, el, efr, ergb, ehs, evs);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nc++;
      if (got !== exp) begin
         nf++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_pos(input int h, input int v, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (int'(horiz_pos) == h && int'(vert_pos) == v) return;
      end
      nc++; nf++;
      $display("FAIL wait_pos(%0d,%0d): not reached within %0d cycles", h, v, budget);
   endtask

   function automatic logic [31:0] rgb();
      return 32'({vga_r, vga_g, vga_b});
   endfunction

   task automatic reset_state(input string tag);
      chk({tag, "_h"}, 32'(horiz_pos), 32'd799);
      chk({tag, "_v"}, 32'(vert_pos), 32'd66);
      chk({tag, "_line_frame"}, 32'({line, frame}), 32'd0);
      chk({tag, "_rgb"}, rgb(), 32'h000);
      chk({tag, "_syncs"}, 32'({vga_hs, vga_vs}), 32'd3);
   endtask

   initial begin
      #1 reset_button = 1'b0;
      chk_on = 1'b1;
      repeat (5) @(negedge clk);
      reset_state("reset_hold");

      reset_button = 1'b1;
      @(negedge clk);
      chk("first_edge_hv", 32'({horiz_pos, vert_pos}), 32'd0);
      chk("first_edge_line_frame", 32'({line, frame}), 32'd3);
      @(negedge clk);
      chk("second_edge_line", 32'(line), 32'd0);
      chk("second_edge_h", 32'(horiz_pos), 32'd1);

      // Row 0 and column edges (border colour only when the feature is built in).
      wait_pos(3, 0, 100);      chk("row0_col0", rgb(), 32'(EDGE_RGB));
      wait_pos(300, 0, 1000);   chk("row0_col297", rgb(), 32'(EDGE_RGB));
      wait_pos(3, 10, 20000);   chk("row10_col0", rgb(), 32'(EDGE_RGB));
      @(negedge clk);           chk("row10_col1", rgb(), 32'h00F);
      wait_pos(642, 10, 1000);  chk("row10_col639", rgb(), 32'(EDGE_RGB));
      wait_pos(2, 11, 1000);
      pix = 1'b1; drawing = 1'b1;
      @(negedge clk);
      pix = 1'b0; drawing = 1'b0;
      chk("row11_col0_sprite", rgb(), 32'hFFF);

      // Single sprite pixel at column 100 of line 50.
      wait_pos(102, 50, 40000); chk("sprite_left_nbr", rgb(), 32'h00F);
      pix = 1'b1; drawing = 1'b1;
      @(negedge clk);
      pix = 1'b0; drawing = 1'b0;
      chk("sprite_pixel", rgb(), 32'hFFF);
      @(negedge clk);           chk("sprite_right_nbr", rgb(), 32'h00F);

      // drawing with pix=0 is background; pix during blanking is black.
      wait_pos(200, 51, 1000);
      drawing = 1'b1;
      @(negedge clk);           drawing = 1'b0;
      chk("drawing_no_pix", rgb(), 32'h00F);
      wait_pos(690, 51, 1000);
      pix = 1'b1; drawing = 1'b1;
      wait_pos(703, 51, 100);   chk("blank_sprite", rgb(), 32'h000);
      wait_pos(720, 51, 100);
      pix = 1'b0; drawing = 1'b0;

      wait_pos(658, 52, 1000);  chk("hs_before", 32'(vga_hs), 32'd1);
      @(negedge clk);           chk("hs_first_low", 32'(vga_hs), 32'd0);
      wait_pos(754, 52, 200);   chk("hs_last_low", 32'(vga_hs), 32'd0);
      @(negedge clk);           chk("hs_after", 32'(vga_hs), 32'd1);

      wait_pos(100, 59, 10000); chk("row59", rgb(), 32'(EDGE_RGB));
      wait_pos(100, 60, 1000);  chk("row60_blank", rgb(), 32'h000);

      wait_pos(2, 62, 5000);    chk("vs_before", 32'(vga_vs), 32'd1);
      @(negedge clk);           chk("vs_first_low", 32'(vga_vs), 32'd0);
      wait_pos(2, 64, 2000);    chk("vs_last_low", 32'(vga_vs), 32'd0);
      @(negedge clk);           chk("vs_after", 32'(vga_vs), 32'd1);

      wait_pos(0, 0, 5000);
      chk("frame2_pulse", 32'(frame), 32'd1);
      chk("frame_period", 32'(k), 32'd53601);
      chk("lines_per_frame", 32'(nlines), 32'd67);
      chk("frames_per_frame", 32'(nframes), 32'd1);

      // Async reset mid-line, no clock edge needed.
      wait_pos(300, 3, 3000);
      #3 reset_button = 1'b0;
      #1 reset_state("async_reset");
      repeat (3) @(negedge clk);
      reset_button = 1'b1;
      @(negedge clk);
      chk("restart_hv", 32'({horiz_pos, vert_pos}), 32'd0);
      chk("restart_line_frame", 32'({line, frame}), 32'd3);
      repeat (10) @(negedge clk);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
      $finish;
   end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster timing generator and pixel compositor for the sprite path. It produces the screen scan coordinates and per-line start pulse consumed by the sprite renderer, then takes back the renderer's `pix`/`drawing` stream. It aligns that stream with delayed sync/blank timing and drives the 12-bit VGA pins. One `clk` cycle is one pixel.

## Interface
- `COORDINATE_WIDTH`, 10, width of `horiz_pos`/`vert_pos`
- `H_RES`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch (H_TOTAL = 800)
- `V_RES`, 480, active lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch (V_TOTAL = 525)
- `SX_OFFS`, 2, renderer latency in cycles from coordinate to `pix`; minimum 1
- `FG_RGB`, 12'hFFF, sprite colour
- `BG_RGB`, 12'h00F, background colour
- `BORDER_RGB`, 12'hF00, border colour (only with `VGA_BORDER_EN`)

Ports:
- `clk`  in  1  pixel clock
- `reset_button`  in  1  asynchronous, active-low reset
- `horiz_pos`  out  COORDINATE_WIDTH  current column counter, 0..H_TOTAL-1
- `vert_pos`  out  COORDINATE_WIDTH  current line counter, 0..V_TOTAL-1
- `line`  out  1  one-cycle pulse in the cycle where `horiz_pos`==0 (every line, including blanking lines)
- `frame`  out  1  one-cycle pulse in the cycle where `horiz_pos`==0 and `vert_pos`==0
- `pix`  in  1  sprite pixel value from renderer
- `drawing`  in  1  renderer is emitting a valid `pix`
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour outputs
- `vga_hs`, `vga_vs`  out  1 each  syncs, active low

## Operation
- Counters: `horiz_pos` increments every cycle and wraps H_TOTAL-1→0. On that wrap, `vert_pos` increments and wraps V_TOTAL-1→0.
- `line` and `frame` are registered. They are set on the clock edge that loads `horiz_pos`=0, so they are high exactly while the counter reads 0.
- Raw decode from the counters:
  - de = h<H_RES && v<V_RES
  - hs_n low for H_RES+H_FP ≤ h < H_RES+H_FP+H_SYNC (656..751)
  - vs_n low for V_RES+V_FP ≤ v < V_RES+V_FP+V_SYNC (490..491)
- Alignment: de, hs_n and vs_n pass through an SX_OFFS-deep shift register. The stage-SX_OFFS values are combined with `pix`/`drawing` sampled in the same cycle, and the result is registered into the VGA outputs.
- Colour priority:
  - delayed de=0 → RGB 0
  - else drawing&&pix → FG_RGB
  - else (border, if enabled) → BORDER_RGB
  - else → BG_RGB
- `drawing`=1 with `pix`=0 shows background. `pix` is ignored when `drawing`=0.

## Timing
- Reset (async assert, any cycle, including mid-line or mid-sync):
  - `horiz_pos`=H_TOTAL-1, `vert_pos`=V_TOTAL-1
  - `line`=0, `frame`=0
  - `vga_r/g/b`=0, `vga_hs`=`vga_vs`=1
  - delay line holds de=0, hs_n=vs_n=1
- First edge after reset deassertion: counters become (0,0), and `line` and `frame` assert.
- Latency: the coordinate presented in cycle t appears on the VGA pins in cycle t+SX_OFFS+1. `pix`/`drawing` sampled in cycle t+SX_OFFS are composed with that coordinate.
- Syncs carry the same SX_OFFS+1 delay as colour, so sync/colour skew is zero.
- Frame period is exactly 800×525 = 420000 cycles. `frame` pulses once per period; `line` pulses 525 times per period.
- Simultaneous horizontal and vertical wrap at (799,524): both counters go to 0 on the same edge.
- No handshake: inputs are sampled every cycle, and the renderer must meet the SX_OFFS latency contract.

## Configuration
- `VGA_BORDER_EN` defined: active pixels at delayed h∈{0,H_RES-1} or v∈{0,V_RES-1} use BORDER_RGB unless the sprite pixel is set. Delayed h/v are carried through the SX_OFFS delay line for this.
- Not defined: no border logic and no coordinate delay; only BG_RGB/FG_RGB are produced.

## Test plan
- Reset release: hold `reset_button`=0 for 5 cycles → outputs at reset values. First edge after release → h=0, v=0, `line`=`frame`=1; next cycle `line`=0.
- Full frame run → `line` period 800 cycles. `frame` period 420000. `vga_hs` low 96 cycles starting SX_OFFS+1 after h=656. `vga_vs` low for 1600 cycles starting at line 490.
- Drive `drawing`=1, `pix`=1 only in the cycle when h=100+SX_OFFS on line 50 → exactly one pixel of 12'hFFF at h=100 position, i.e. pin cycle h=100+SX_OFFS+1. Neighbours show 12'h00F.
- `drawing`=1 and `pix`=1 held during blanking (h=700) → RGB stays 0.
- Async reset asserted at h=300, v=200 → outputs go to reset values immediately without a clock. After release, the frame restarts at (0,0).
- `VGA_BORDER_EN`, no sprite → pixel h=0 and h=639 of line 10 are 12'hF00, h=1 is 12'h00F, all of line 0 and line 479 are 12'hF00. With the sprite set at h=0 → 12'hFFF.
